// File: rtl/run_control_monitor_pkg.sv
// Shared types for the run-control monitor: FSM states and halt cause codes.
package run_control_monitor_pkg;

  // state    | meaning
  // ST_IDLE  | out of reset, core held, waiting for start
  // ST_RUN   | core clocked, retirements counted, halt events watched
  // ST_DRAIN | one dead cycle after the halt, core already stopped
  // ST_DUMP  | streaming the state window over the trace port
  // ST_DONE  | dump complete, waiting for the next start
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } rcm_state_e;

  typedef enum logic [2:0] {
    HALT_NONE  = 3'd0,
    HALT_LIMIT = 3'd1,
    HALT_BP    = 3'd2,
    HALT_LOOP  = 3'd3,
    HALT_EXT   = 3'd4
  } halt_cause_e;

  // Lowest code wins when several halt events fire in the same cycle.
  function automatic halt_cause_e pick_cause(input logic lim, input logic bp,
                                             input logic lp, input logic ext);
    if (lim) return HALT_LIMIT;
    if (bp)  return HALT_BP;
    if (lp)  return HALT_LOOP;
    if (ext) return HALT_EXT;
    return HALT_NONE;
  endfunction

endpackage

// File: rtl/run_control_monitor_bp_match.sv
// Parallel PC breakpoint comparators; one match bit per enabled breakpoint.
module rcm_bp_match #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 2
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic [NUM_BP-1:0]      match
);

  // Compare the retiring pc against every enabled breakpoint address.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
    end
  end

endmodule

// File: rtl/run_control_monitor.sv
// Run-control monitor: counts retirements, halts the core on limit, breakpoint,
// self-loop or external stop, then streams a window of architectural state.
module run_control_monitor
  import run_control_monitor_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int CYCLE_LIMIT = 40,
  parameter int NUM_BP      = 2,
  parameter int LOOP_THRESH = 4,
  parameter int DUMP_WORDS  = 34,
  parameter int IDX_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   ext_stop,
  input  logic                   retire,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   core_run,
  output logic                   dump_rd_en,
  output logic [IDX_W-1:0]       dump_rd_idx,
  input  logic [31:0]            dump_rd_data,
  output logic                   trace_valid,
  output logic [IDX_W-1:0]       trace_idx,
  output logic [31:0]            trace_data,
  input  logic                   trace_ready,
  output logic [2:0]             halt_cause,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic                   done
);

  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(CYCLE_LIMIT);
  localparam logic [CNT_W-1:0] LOOP_C   = CNT_W'(LOOP_THRESH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);
  localparam bit               LIMIT_ON = (CYCLE_LIMIT != 0);

  rcm_state_e        state, state_nxt;
  halt_cause_e       cause_q, cause_now;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic [CNT_W-1:0]  loop_q, loop_nxt;
  logic [PC_W-1:0]   last_pc_q;
  logic [NUM_BP-1:0] bp_match;
  logic              lim_ev, bp_ev, loop_ev, halt_ev, start_run;
  logic [IDX_W-1:0]  idx_q;
  logic              present_q, fresh_q;
  logic [31:0]       hold_q;

  rcm_bp_match #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_bp_match (
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .match   (bp_match)
  );

  // Post-increment count and loop count, and the halt events they imply this cycle.
  always_comb begin
    cnt_inc = cnt_q;
    if (retire && (cnt_q != '1)) cnt_inc = cnt_q + 1'b1;
    loop_nxt = CNT_W'(1);
    if (pc == last_pc_q) loop_nxt = (loop_q == '1) ? loop_q : loop_q + 1'b1;
    lim_ev    = LIMIT_ON && (cnt_inc >= LIMIT_C);
    bp_ev     = retire && (|bp_match);
    loop_ev   = retire && (loop_nxt == LOOP_C);
    cause_now = pick_cause(lim_ev, bp_ev, loop_ev, ext_stop);
    halt_ev   = (cause_now != HALT_NONE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_nxt   = state;
    start_run   = 1'b0;
    core_run    = 1'b0;
    done        = 1'b0;
    dump_rd_en  = 1'b0;
    trace_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_RUN: begin
        core_run = 1'b1;
        if (halt_ev) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DUMP;
      ST_DUMP: begin
        dump_rd_en  = !present_q;
        trace_valid = present_q;
        if (present_q && trace_ready && (idx_q == LAST_IDX)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = ST_RUN;
          start_run = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Retire counter, self-loop tracker and latched halt cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      loop_q    <= '0;
      last_pc_q <= '0;
      cause_q   <= HALT_NONE;
    end else if (start_run) begin
      cnt_q   <= '0;
      loop_q  <= '0;
      cause_q <= HALT_NONE;
    end else if (state == ST_RUN) begin
      if (retire) begin
        cnt_q     <= cnt_inc;
        loop_q    <= loop_nxt;
        last_pc_q <= pc;
      end
      if (halt_ev) cause_q <= cause_now;
    end
  end

  // Dump sequencer: issue read k, present it, hold it until accepted, then issue k+1.
  // The read word appears the cycle after the strobe; it is passed straight through on
  // that first cycle and held locally afterwards so backpressure cannot corrupt it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      present_q <= 1'b0;
      fresh_q   <= 1'b0;
      hold_q    <= '0;
    end else if (state == ST_DRAIN) begin
      idx_q     <= '0;
      present_q <= 1'b0;
      fresh_q   <= 1'b0;
    end else if (state == ST_DUMP) begin
      if (!present_q) begin
        present_q <= 1'b1;
        fresh_q   <= 1'b1;
      end else begin
        fresh_q <= 1'b0;
        if (fresh_q) hold_q <= dump_rd_data;
        if (trace_ready) begin
          present_q <= 1'b0;
          if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign dump_rd_idx = idx_q;
  assign trace_idx   = idx_q;
  assign trace_data  = trace_valid ? (fresh_q ? dump_rd_data : hold_q) : '0;
  assign halt_cause  = cause_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_run_control_monitor.sv
// Randomized bench for run_control_monitor with a run-level reference model.
module tb_run_control_monitor;
  import run_control_monitor_pkg::*;

  localparam int PC_W = 32, CNT_W = 16, NUM_BP = 2, IDX_W = 6;
  localparam int DUMP_WORDS = 34, LIMIT = 40, LOOP_TH = 4;

  logic                   clk, rst, start, ext_stop, retire;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;
  logic                   core_run, dump_rd_en, trace_valid, trace_ready, done;
  logic [IDX_W-1:0]       dump_rd_idx, trace_idx;
  logic [31:0]            dump_rd_data, trace_data;
  logic [2:0]             halt_cause;
  logic [CNT_W-1:0]       retired_cnt;

  run_control_monitor #(
    .PC_W(PC_W), .CNT_W(CNT_W), .CYCLE_LIMIT(LIMIT), .NUM_BP(NUM_BP),
    .LOOP_THRESH(LOOP_TH), .DUMP_WORDS(DUMP_WORDS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ext_stop(ext_stop), .retire(retire),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .core_run(core_run),
    .dump_rd_en(dump_rd_en), .dump_rd_idx(dump_rd_idx), .dump_rd_data(dump_rd_data),
    .trace_valid(trace_valid), .trace_idx(trace_idx), .trace_data(trace_data),
    .trace_ready(trace_ready), .halt_cause(halt_cause), .retired_cnt(retired_cnt),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State-mux stand-in: registered read of the dump window.
  logic [31:0] mem [DUMP_WORDS];
  always @(posedge clk) begin
    if (dump_rd_en)
      dump_rd_data <= (int'(dump_rd_idx) < DUMP_WORDS) ? mem[dump_rd_idx] : 32'hDEAD_BEEF;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of one run.
  int          m_cnt;
  int          m_cause;
  bit          m_halted;
  logic [31:0] hist [$];

  function automatic logic [31:0] prog_pc(input int prog, input int n);
    case (prog)
      0:       return 32'((n % 15) * 4);
      1:       return 32'(n * 4);
      2:       return 32'(((n < 15) ? n : 15) * 4);
      default: return 32'($urandom_range(0, 5) * 4);
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [31:0] p, input logic e,
                            input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1);
    bit lim, bpv, lp;
    if (r) begin
      if (m_cnt < 65535) m_cnt++;
      hist.push_back(p);
    end
    lim = (m_cnt >= LIMIT);
    bpv = r && ((en[0] && p == a0) || (en[1] && p == a1));
    lp  = r && (hist.size() >= LOOP_TH);
    if (lp)
      for (int i = 0; i < LOOP_TH; i++)
        if (hist[hist.size() - 1 - i] != p) lp = 0;
    if (lim)      m_cause = HALT_LIMIT;
    else if (bpv) m_cause = HALT_BP;
    else if (lp)  m_cause = HALT_LOOP;
    else if (e)   m_cause = HALT_EXT;
    if (m_cause != 0) m_halted = 1;
  endtask

  // One start-to-done run; entered and left at a negedge.
  task automatic do_run(input string tag, input int prog, input logic [1:0] en,
                        input logic [31:0] a0, input logic [31:0] a1, input int ext_at,
                        input int rdy_mode, input int abort_at, input int exp_cause,
                        input int exp_cnt);
    logic        r, e, rdy, pending;
    logic [31:0] p, sv_data, exp_data;
    logic [IDX_W-1:0] sv_idx;
    bit          seen_halt;
    int          k, last_acc;
    bp_en   = en;
    bp_addr = {a1, a0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_cnt = 0; m_cause = 0; m_halted = 0; hist.delete();
    seen_halt = 0;
    for (int c = 0; c < 400; c++) begin
      check_val({tag, "_core_run"}, core_run, !m_halted);
      check_val({tag, "_cnt"}, retired_cnt, m_cnt);
      check_val({tag, "_cause_run"}, halt_cause, m_cause);
      if (m_halted) begin
        seen_halt = 1;
        break;
      end
      r = ($urandom_range(0, 3) != 0);
      p = prog_pc(prog, m_cnt);
      e = (ext_at >= 0) && (c >= ext_at);
      retire = r; pc = p; ext_stop = e;
      model_step(r, p, e, en, a0, a1);
      @(negedge clk);
    end
    retire = 1'b0; ext_stop = 1'b0;
    if (!seen_halt) check_val({tag, "_halt_timeout"}, 0, 1);
    if (exp_cause >= 0) check_val({tag, "_cause_spec"}, halt_cause, exp_cause);
    if (exp_cnt >= 0)   check_val({tag, "_cnt_spec"}, retired_cnt, exp_cnt);

    k = 0; last_acc = -1; pending = 0;
    for (int c = 0; c < 600; c++) begin
      if (done) break;
      if (abort_at >= 0 && trace_valid && k == abort_at) begin
        rst = 1'b1;
        #1;
        check_val({tag, "_abort_valid"}, trace_valid, 0);
        check_val({tag, "_abort_run"}, core_run, 0);
        check_val({tag, "_abort_rd"}, dump_rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        trace_ready = 1'b0;
        check_val({tag, "_abort_cause"}, halt_cause, 0);
        check_val({tag, "_abort_cnt"}, retired_cnt, 0);
        return;
      end
      if (pending) begin
        check_val({tag, "_hold_valid"}, trace_valid, 1);
        check_val({tag, "_hold_idx"}, trace_idx, sv_idx);
        check_val({tag, "_hold_data"}, trace_data, sv_data);
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = c[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      trace_ready = rdy;
      pending = 0;
      if (trace_valid) begin
        if (rdy) begin
          exp_data = (k < DUMP_WORDS) ? mem[k] : 32'hFFFF_FFFF;
          check_val({tag, "_idx"}, trace_idx, k);
          check_val({tag, "_data"}, trace_data, exp_data);
          if (rdy_mode == 0 && last_acc >= 0) check_val({tag, "_rate"}, c - last_acc, 2);
          last_acc = c;
          k++;
        end else begin
          pending = 1;
          sv_idx  = trace_idx;
          sv_data = trace_data;
        end
      end
      @(negedge clk);
    end
    trace_ready = 1'b0;
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_words"}, k, DUMP_WORDS);
    check_val({tag, "_cause_done"}, halt_cause, m_cause);
    check_val({tag, "_run_done"}, core_run, 0);
  endtask

  initial begin
    logic [1:0]  ren;
    logic [31:0] ra0, ra1;
    int          rext;
    rst = 1'b1; start = 1'b0; ext_stop = 1'b0; retire = 1'b0; pc = '0;
    bp_addr = '0; bp_en = '0; trace_ready = 1'b0;
    for (int k = 0; k < DUMP_WORDS; k++) mem[k] = 32'(k * 3);
    repeat (3) @(negedge clk);
    check_val("rst_core_run", core_run, 0);
    check_val("rst_done", done, 0);
    check_val("rst_trace_valid", trace_valid, 0);
    check_val("rst_rd_en", dump_rd_en, 0);
    check_val("rst_cause", halt_cause, 0);
    check_val("rst_cnt", retired_cnt, 0);
    check_val("rst_trace_data", trace_data, 0);
    rst = 1'b0;
    @(negedge clk);

    do_run("limit",    0, 2'b00, 32'h0,  32'h0,  -1, 1, -1, HALT_LIMIT, 40);
    do_run("bp",       0, 2'b01, 32'h1C, 32'h0,  -1, 0, -1, HALT_BP,    8);
    do_run("selfloop", 2, 2'b00, 32'h0,  32'h0,  -1, 2, -1, HALT_LOOP,  19);
    do_run("lim_bp",   1, 2'b10, 32'h0,  32'h9C, -1, 1, -1, HALT_LIMIT, 40);
    do_run("ext",      0, 2'b00, 32'h0,  32'h0,  10, 2, -1, HALT_EXT,   -1);
    do_run("abort",    0, 2'b01, 32'h30, 32'h0,  -1, 1, 10, HALT_BP,    13);
    do_run("after",    0, 2'b00, 32'h0,  32'h0,  -1, 0, -1, HALT_LIMIT, 40);

    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < DUMP_WORDS; k++) mem[k] = $urandom;
      ren  = 2'($urandom_range(0, 3));
      ra0  = 32'($urandom_range(0, 19) * 4);
      ra1  = 32'($urandom_range(0, 19) * 4);
      rext = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 50)) : -1;
      do_run("rand", int'($urandom_range(0, 3)), ren, ra0, ra1, rext, 2, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
